// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between the control path and alu_sequencer.
// Latency: none (wires only).
// Backpressure: req_ready stalls the requester; rsp_ready stalls the sequencer's response.
//   req_valid/req_ready/req_op/req_a/req_b : operation request, valid/ready
//   rsp_valid/rsp_ready/rsp_result/rsp_err : result response, valid/ready
interface alu_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;

    // Requester / response consumer side.
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_err
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Front-end controller owning the 32-bit ALU inputs; single-cycle ops pass through, mod (111) iterates via subtract.
// Latency: accept edge 0 -> rsp_valid in cycle 2 for ops 000-110, cycle 1 for mod-by-zero, cycle k+2 for a mod of k subtractions.
// Backpressure: one op in flight; req_ready only in IDLE; response held in RESP until rsp_ready, next accept one cycle later.
//   clk, reset (sync, active-low) : clock and reset
//   bus (alu_sequencer_if.slave)  : request/response handshake
//   alu_a/alu_b/alu_op/alu_result : ALU operand/opcode drive and combinational result
//   busy                          : high whenever not IDLE
module alu_sequencer #(
    parameter int MAX_ITER = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_sequencer_if.slave         bus,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    output logic [2:0]             alu_op,
    input  logic [31:0]            alu_result,
    output logic                   busy
);
    localparam int CNT_W = $clog2(MAX_ITER + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ITER);
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        MOD_LOOP = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      rem;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      result_q;
    logic             err_q;

    logic             req_ready_c;
    logic             rsp_valid_c;
    logic             accept;
    logic             rem_lt_b;
    logic             cap_hit;

    assign accept   = bus.req_valid && req_ready_c;
    // Loop exit uses a private unsigned compare so the ALU stays dedicated to the subtract.
    assign rem_lt_b = rem < b_q;
    assign cap_hit  = cnt == CNT_MAX;

    assign bus.req_ready  = req_ready_c;
    assign bus.rsp_valid  = rsp_valid_c;
    assign bus.rsp_result = result_q;
    assign bus.rsp_err    = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        busy        = 1'b1;
        alu_a       = 32'd0;
        alu_b       = 32'd0;
        alu_op      = 3'b000;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                busy        = 1'b0;
                if (bus.req_valid) begin
                    if (bus.req_op != OP_MOD) begin
                        state_nxt = ISSUE;
                    end else if (bus.req_b == 32'd0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = MOD_LOOP;
                    end
                end
            end
            ISSUE: begin
                alu_op    = op_q;
                alu_a     = a_q;
                alu_b     = b_q;
                state_nxt = RESP;
            end
            MOD_LOOP: begin
                alu_op = OP_SUB;
                alu_a  = rem;
                alu_b  = b_q;
                if (rem_lt_b || cap_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q     <= 3'b000;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            rem      <= 32'd0;
            cnt      <= '0;
            result_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= bus.req_op;
                        a_q  <= bus.req_a;
                        b_q  <= bus.req_b;
                        rem  <= bus.req_a;
                        cnt  <= '0;
                        // Mod by zero skips the loop and answers with the dividend.
                        if (bus.req_op == OP_MOD && bus.req_b == 32'd0) begin
                            result_q <= bus.req_a;
                            err_q    <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    result_q <= alu_result;
                    err_q    <= 1'b0;
                end
                MOD_LOOP: begin
                    if (rem_lt_b) begin
                        result_q <= rem;
                        err_q    <= 1'b0;
                    end else if (cap_hit) begin
                        // Partial remainder is reported alongside the error flag.
                        result_q <= rem;
                        err_q    <= 1'b1;
                    end else begin
                        rem <= alu_result;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
